regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the fixed 16x16, one-write/two-read file in the CPU datapath.
- Adds generic width and depth, a second write port for the load/writeback path, and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so the control FSM can stall on pending producers.
- Sits between the decoder/control unit and the ALU operand buses.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 16, number of registers; power of two, >=2.
- AW, log2(DEPTH), select width; derived, not overridden.
- ZERO_REG, 0: if 1, register 0 always reads 0, ignores writes and never becomes busy.
- BYPASS, 1: if 1, read ports forward same-cycle write data and busy-clear.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w0_en  in  1  write port 0 enable (ALU result)
- w0_sel  in  AW  write port 0 register select
- w0_data  in  WIDTH  write port 0 data
- w1_en  in  1  write port 1 enable (load result)
- w1_sel  in  AW  write port 1 register select
- w1_data  in  WIDTH  write port 1 data
- rsv_en  in  1  reserve request: mark register busy
- rsv_sel  in  AW  register to reserve
- a_sel  in  AW  read port A select
- b_sel  in  AW  read port B select
- a  out  WIDTH  read port A data
- b  out  WIDTH  read port B data
- a_busy  out  1  busy bit of register a_sel
- b_busy  out  1  busy bit of register b_sel
- wr_conflict  out  1  registered flag: last cycle had w0 and w1 targeting the same register

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, wr_conflict = 0. Outputs therefore read 0 / not busy immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- Storage: DEPTH x WIDTH flops. Register i updates on a rising clk edge when w0 or w1 targets it.
- Write conflict: w0_en and w1_en both set with w0_sel == w1_sel -> port 0 data is written; wr_conflict = 1 on the next cycle, otherwise wr_conflict = 0.
- Reads: a and b are combinational from a_sel and b_sel (zero-latency, as in the previous generation).
  - BYPASS=1 and a same-cycle write hits the selected register: output shows that write's data, port 0 taking priority.
  - BYPASS=0: output shows the stored value; new data is visible the cycle after the edge.
- Scoreboard:
  - A write on either port clears the busy bit of its target register at the edge.
  - rsv_en sets the busy bit of rsv_sel at the edge.
  - Reserve and write to the same register in the same cycle: the busy bit is set (reserve wins, since a new producer is outstanding), and the data write still happens.
  - Reserving an already-busy register: stays busy, no error.
- a_busy/b_busy: combinational busy bit of the selected register.
  - BYPASS=1: busy reads 0 if a same-cycle write clears it, unless a same-cycle reserve targets the same register.
  - BYPASS=0: shows the stored bit.
- ZERO_REG=1:
  - Selecting register 0 gives a=0 or b=0 and busy=0.
  - Writes and reserves to register 0 are dropped.
  - wr_conflict is still flagged for sel 0.
- Reset asserted mid-cycle overrides all pending writes and reserves.
- No combinational path from inputs to wr_conflict.
- Select width AW is exact: every select value is legal, so there is no out-of-range case.

Test Plan:
- Reset and basic write/read: assert rst_n=0 with random prior contents -> a, b, a_busy, b_busy all 0 while low. Release, write w0 reg5=0x1234 -> next cycle a_sel=5 gives a=0x1234.
- Dual write, distinct and conflicting:
  - Same cycle w0 reg3=0xAAAA, w1 reg7=0x5555 -> both stored, wr_conflict=0.
  - Same cycle w0 reg4=0x1111, w1 reg4=0x2222 -> reg4=0x1111, wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, reg9 holds 0x0001; same cycle w1 reg9=0xBEEF with b_sel=9 -> b=0xBEEF before the edge. With BYPASS=0 -> b=0x0001 before the edge, 0xBEEF after.
- Scoreboard:
  - rsv reg2 -> a_busy=1 from the next cycle; w0 reg2=0x0F0F -> busy cleared after the edge.
  - Same-cycle rsv reg2 plus write reg2 -> busy remains 1 and data = new value.
- ZERO_REG=1: write reg0=0xFFFF and rsv reg0 -> a_sel=0 gives a=0, a_busy=0. With w0 and w1 both targeting reg0 -> wr_conflict=1.
- Asynchronous reset mid-operation: pulse rst_n low between clock edges while reg12 is busy and holds 0x7777 -> reg12=0 and busy=0 immediately. Writes presented during reset are lost.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised two-write / two-read register file with a
// per-register busy scoreboard and optional same-cycle read bypass.
module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w0_en,
  input  logic [AW-1:0]    w0_sel,
  input  logic [WIDTH-1:0] w0_data,
  input  logic             w1_en,
  input  logic [AW-1:0]    w1_sel,
  input  logic [WIDTH-1:0] w1_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  input  logic [AW-1:0]    a_sel,
  input  logic [AW-1:0]    b_sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_busy,
  output logic             b_busy,
  output logic             wr_conflict
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] keep;
  logic [DEPTH-1:0] w0_hit;
  logic [DEPTH-1:0] w1_hit;
  logic [DEPTH-1:0] rsv_hit;
  logic [DEPTH-1:0] clr_byp;
  logic             conflict;
  logic             byp;

  // register 0 is masked out of every write/reserve when hardwired
  assign keep    = ZERO_REG ? ~DEPTH'(1) : '1;
  assign w0_hit  = w0_en ? ((DEPTH'(1) << w0_sel) & keep) : '0;
  assign w1_hit  = w1_en ? ((DEPTH'(1) << w1_sel) & keep) : '0;
  assign rsv_hit = rsv_en ? ((DEPTH'(1) << rsv_sel) & keep) : '0;
  assign conflict = w0_en & w1_en & (w0_sel == w1_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict;
      for (int i = 0; i < DEPTH; i++) begin
        if (w0_hit[i]) mem[i] <= w0_data;
        else if (w1_hit[i]) mem[i] <= w1_data;
      end
      // a fresh reservation outranks the clear from a retiring write
      busy <= (busy & ~(w0_hit | w1_hit)) | rsv_hit;
    end
  end

  // forwarding is suppressed in reset so outputs read idle at once
  assign clr_byp = (w0_hit | w1_hit) & ~rsv_hit;
  assign byp     = BYPASS & rst_n;

  always_comb begin
    a      = mem[a_sel];
    a_busy = busy[a_sel];
    if (byp) begin
      if (w0_hit[a_sel]) a = w0_data;
      else if (w1_hit[a_sel]) a = w1_data;
      a_busy = a_busy & ~clr_byp[a_sel];
    end
  end

  always_comb begin
    b      = mem[b_sel];
    b_busy = busy[b_sel];
    if (byp) begin
      if (w0_hit[b_sel]) b = w0_data;
      else if (w1_hit[b_sel]) b = w1_data;
      b_busy = b_busy & ~clr_byp[b_sel];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp, checking a bypassing
// instance and a hardwired-zero, non-bypassing instance against a model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        w0_en, w1_en, rsv_en;
  logic [3:0]  w0_sel, w1_sel, rsv_sel, a_sel, b_sel;
  logic [15:0] w0_data, w1_data;

  logic [15:0] a0, b0, a1, b1;
  logic        ab0, bb0, wc0, ab1, bb1, wc1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [2][16];
  logic        busy_m [2][16];
  logic        conf_m;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .w0_en(w0_en), .w0_sel(w0_sel), .w0_data(w0_data),
    .w1_en(w1_en), .w1_sel(w1_sel), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .a_sel(a_sel), .b_sel(b_sel),
    .a(a0), .b(b0), .a_busy(ab0), .b_busy(bb0),
    .wr_conflict(wc0)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .w0_en(w0_en), .w0_sel(w0_sel), .w0_data(w0_data),
    .w1_en(w1_en), .w1_sel(w1_sel), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .a_sel(a_sel), .b_sel(b_sel),
    .a(a1), .b(b1), .a_busy(ab1), .b_busy(bb1),
    .wr_conflict(wc1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // cfg 0: plain regs with bypass; cfg 1: reg0 hardwired, no bypass
  function automatic bit dropped(input int c, input logic [3:0] s);
    return c == 1 && s == 4'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_m <= 1'b0;
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 16; r++) begin
          mem_m[c][r]  <= 16'h0;
          busy_m[c][r] <= 1'b0;
        end
    end else begin
      conf_m <= w0_en && w1_en && (w0_sel == w1_sel);
      for (int c = 0; c < 2; c++) begin
        // later assignments win: w1 < w0 for data, write < reserve for busy
        if (w1_en && !dropped(c, w1_sel)) begin
          mem_m[c][w1_sel]  <= w1_data;
          busy_m[c][w1_sel] <= 1'b0;
        end
        if (w0_en && !dropped(c, w0_sel)) begin
          mem_m[c][w0_sel]  <= w0_data;
          busy_m[c][w0_sel] <= 1'b0;
        end
        if (rsv_en && !dropped(c, rsv_sel)) busy_m[c][rsv_sel] <= 1'b1;
      end
    end
  end

  function automatic logic [15:0] exp_data(input int c, input logic [3:0] s);
    if (!rst_n || dropped(c, s)) return 16'h0;
    if (c == 0 && w0_en && w0_sel == s) return w0_data;
    if (c == 0 && w1_en && w1_sel == s) return w1_data;
    return mem_m[c][s];
  endfunction

  function automatic logic exp_busy(input int c, input logic [3:0] s);
    bit wr;
    bit rs;
    if (!rst_n || dropped(c, s)) return 1'b0;
    wr = (w0_en && w0_sel == s) || (w1_en && w1_sel == s);
    rs = rsv_en && rsv_sel == s;
    if (c == 0 && wr && !rs) return 1'b0;
    return busy_m[c][s];
  endfunction

  always @(negedge clk) begin
    chk("a0", a0, exp_data(0, a_sel));
    chk("b0", b0, exp_data(0, b_sel));
    chk("a_busy0", ab0, exp_busy(0, a_sel));
    chk("b_busy0", bb0, exp_busy(0, b_sel));
    chk("wr_conflict0", wc0, conf_m);
    chk("a1", a1, exp_data(1, a_sel));
    chk("b1", b1, exp_data(1, b_sel));
    chk("a_busy1", ab1, exp_busy(1, a_sel));
    chk("b_busy1", bb1, exp_busy(1, b_sel));
    chk("wr_conflict1", wc1, conf_m);
  end

  task automatic idle();
    w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [3:0] s, input logic [15:0] d);
    w0_en = 1'b1; w0_sel = s; w0_data = d;
  endtask

  task automatic wr1(input logic [3:0] s, input logic [15:0] d);
    w1_en = 1'b1; w1_sel = s; w1_data = d;
  endtask

  task automatic rsv(input logic [3:0] s);
    rsv_en = 1'b1; rsv_sel = s;
  endtask

  initial begin
    idle();
    w0_sel = '0; w1_sel = '0; rsv_sel = '0;
    w0_data = '0; w1_data = '0;
    a_sel = '0; b_sel = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // random contents, all reserved, then an asynchronous reset
    a_sel = 4'd3; b_sel = 4'd7;
    for (int i = 1; i < 16; i++) begin
      idle();
      wr0(4'(i), 16'($urandom));
      rsv(4'(i));
      tick();
    end
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_a", a0, 16'h0);
    chk("rst_b", b0, 16'h0);
    chk("rst_a_busy", ab0, 1'b0);
    chk("rst_b_busy", bb0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic write then read
    wr0(4'd5, 16'h1234);
    tick();
    idle();
    a_sel = 4'd5;
    #1;
    chk("w5_a0", a0, 16'h1234);
    chk("w5_a1", a1, 16'h1234);

    // dual distinct write
    tick();
    wr0(4'd3, 16'hAAAA);
    wr1(4'd7, 16'h5555);
    tick();
    idle();
    a_sel = 4'd3; b_sel = 4'd7;
    #1;
    chk("dual_a", a0, 16'hAAAA);
    chk("dual_b", b1, 16'h5555);
    chk("dual_conf", wc0, 1'b0);

    // conflicting write: port 0 wins, flag for one cycle
    tick();
    wr0(4'd4, 16'h1111);
    wr1(4'd4, 16'h2222);
    tick();
    idle();
    a_sel = 4'd4;
    #1;
    chk("conf_a", a0, 16'h1111);
    chk("conf_flag", wc0, 1'b1);
    tick();
    chk("conf_clear", wc0, 1'b0);

    // bypass versus registered read
    wr0(4'd9, 16'h0001);
    tick();
    idle();
    wr1(4'd9, 16'hBEEF);
    b_sel = 4'd9;
    #1;
    chk("byp_b0", b0, 16'hBEEF);
    chk("nobyp_b1", b1, 16'h0001);
    tick();
    idle();
    #1;
    chk("after_b1", b1, 16'hBEEF);

    // scoreboard: reserve, then clear by write
    tick();
    a_sel = 4'd2;
    rsv(4'd2);
    #1;
    chk("rsv_pre", ab0, 1'b0);
    tick();
    idle();
    #1;
    chk("rsv_busy0", ab0, 1'b1);
    chk("rsv_busy1", ab1, 1'b1);
    wr0(4'd2, 16'h0F0F);
    #1;
    chk("clr_byp0", ab0, 1'b0);
    chk("clr_nobyp1", ab1, 1'b1);
    tick();
    idle();
    #1;
    chk("clr_busy0", ab0, 1'b0);
    chk("clr_busy1", ab1, 1'b0);
    chk("clr_data", a0, 16'h0F0F);

    // reserve and write together: stays busy, data updates
    wr0(4'd2, 16'h1357);
    rsv(4'd2);
    #1;
    chk("rw_pre", ab0, 1'b0);
    tick();
    idle();
    #1;
    chk("rw_busy", ab0, 1'b1);
    chk("rw_data", a1, 16'h1357);

    // hardwired zero register
    a_sel = 4'd0;
    wr0(4'd0, 16'hFFFF);
    rsv(4'd0);
    tick();
    idle();
    #1;
    chk("z_a1", a1, 16'h0);
    chk("z_busy1", ab1, 1'b0);
    chk("z_a0", a0, 16'hFFFF);
    chk("z_busy0", ab0, 1'b1);
    wr0(4'd0, 16'h0001);
    wr1(4'd0, 16'h0002);
    tick();
    idle();
    #1;
    chk("z_conf1", wc1, 1'b1);
    chk("z_a1_after", a1, 16'h0);

    // asynchronous reset mid-cycle drops pending write
    tick();
    wr0(4'd12, 16'h7777);
    rsv(4'd12);
    tick();
    idle();
    a_sel = 4'd12;
    #1;
    chk("r12_a", a1, 16'h7777);
    chk("r12_busy", ab1, 1'b1);
    wr0(4'd12, 16'h4444);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_a0", a0, 16'h0);
    chk("mid_busy0", ab0, 1'b0);
    chk("mid_a1", a1, 16'h0);
    chk("mid_busy1", ab1, 1'b0);
    idle();
    #2 rst_n = 1'b1;
    tick();
    #1;
    chk("post_a0", a0, 16'h0);
    chk("post_busy1", ab1, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
